uart_rx: RTL and testbench

- 16x-oversampling UART receiver; sits directly downstream of the baud-rate tick generator and consumes its one-cycle `bau_tick` strobe (9600 baud × 16 from 12 MHz, one tick every 78 clk).
- Synchronises the asynchronous serial line and detects and validates the start bit.
- Samples each data bit at mid-bit, checks the stop bit, and presents a parallel byte with a done strobe or a framing-error strobe.

---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 168 ++++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-side and parallel-side signals of the 16x-oversampling UART receiver.
// The receiver takes the slave modport; the baud generator, line and consumer take the master modport.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 bau_tick_i;
  logic                 rx_i;
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_done_o;
  logic                 frame_err_o;
  logic                 busy_o;

  modport slave (
    input  bau_tick_i,
    input  rx_i,
    output rx_data_o,
    output rx_done_o,
    output frame_err_o,
    output busy_o
  );

  modport master (
    output bau_tick_i,
    output rx_i,
    input  rx_data_o,
    input  rx_done_o,
    input  frame_err_o,
    input  busy_o
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: synchronises rx_i, validates the start bit at its midpoint,
// samples data bits LSB first at mid-bit and checks the stop bit.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_ZERO = SW'(0);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] N_ZERO = NW'(0);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    DATA     = 3'd2,
    STOP     = 3'd3,
    BRK_WAIT = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_sync;
  logic                 w_rx_s;
  logic [SW-1:0]        r_s_cnt;
  logic [SW-1:0]        w_s_cnt_nxt;
  logic [NW-1:0]        r_n_cnt;
  logic [NW-1:0]        w_n_cnt_nxt;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] w_shreg_nxt;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 r_done;
  logic                 w_done_nxt;
  logic                 r_ferr;
  logic                 w_ferr_nxt;
  logic                 r_busy;

  // Two-flop synchroniser; idles high so reset does not look like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.rx_i};
    end
  end

  assign w_rx_s = r_sync[1];

  // Next-state, counter, shift and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_n_cnt_nxt = r_n_cnt;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_done_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_cnt_nxt = S_ZERO;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (bus.bau_tick_i) begin
          if (r_s_cnt != S_HALF) begin
            w_s_cnt_nxt = r_s_cnt + S_ONE;
          end else if (!w_rx_s) begin
            w_state_nxt = DATA;
            w_s_cnt_nxt = S_ZERO;
            w_n_cnt_nxt = N_ZERO;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (bus.bau_tick_i) begin
          if (r_s_cnt != S_LAST) begin
            w_s_cnt_nxt = r_s_cnt + S_ONE;
          end else begin
            w_s_cnt_nxt = S_ZERO;
            w_shreg_nxt = {w_rx_s, r_shreg[DATA_BITS-1:1]};
            if (r_n_cnt == N_LAST) begin
              w_state_nxt = STOP;
            end else begin
              w_n_cnt_nxt = r_n_cnt + N_ONE;
            end
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (bus.bau_tick_i) begin
          if (r_s_cnt != S_LAST) begin
            w_s_cnt_nxt = r_s_cnt + S_ONE;
          end else if (w_rx_s) begin
            w_s_cnt_nxt = S_ZERO;
            w_data_nxt  = r_shreg;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_s_cnt_nxt = S_ZERO;
            w_ferr_nxt  = 1'b1;
            w_state_nxt = BRK_WAIT;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      BRK_WAIT: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BRK_WAIT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_s_cnt_nxt = S_ZERO;
        w_n_cnt_nxt = N_ZERO;
      end
    endcase
  end

  // State, datapath and registered outputs; busy tracks the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_s_cnt <= S_ZERO;
      r_n_cnt <= N_ZERO;
      r_shreg <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s_cnt <= w_s_cnt_nxt;
      r_n_cnt <= w_n_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      r_ferr  <= w_ferr_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign bus.rx_data_o   = r_data;
  assign bus.rx_done_o   = r_done;
  assign bus.frame_err_o = r_ferr;
  assign bus.busy_o      = r_busy;
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected strobes, negedge monitors pop and compare.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int BIT8 = 1248;
  localparam int BIT7 = 624;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   cyc;
  exp_t q8[$];
  logic [6:0] q7[$];
  int   done_cyc[$];
  logic prev_busy8;
  logic prev_busy7;

  uart_rx_if #(.DATA_BITS(8)) u_if8();
  uart_rx_if #(.DATA_BITS(7)) u_if7();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) u_dut8 (.clk(clk), .rst(rst), .bus(u_if8.slave));
  uart_rx #(.DATA_BITS(7), .OVERSAMPLE(8))  u_dut7 (.clk(clk), .rst(rst), .bus(u_if7.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // One-clock tick every 78 clocks, shared by both receivers.
  initial begin
    u_if8.bau_tick_i = 1'b0;
    u_if7.bau_tick_i = 1'b0;
    forever begin
      repeat (77) @(negedge clk);
      u_if8.bau_tick_i = 1'b1;
      u_if7.bau_tick_i = 1'b1;
      @(negedge clk);
      u_if8.bau_tick_i = 1'b0;
      u_if7.bau_tick_i = 1'b0;
    end
  end

  initial begin
    #1200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_raw(input logic [15:0] bits, input int n, input int bitlen, input int which);
    for (int i = 0; i < n; i++) begin
      if (which == 0) u_if8.rx_i = bits[i];
      else            u_if7.rx_i = bits[i];
      repeat (bitlen) @(negedge clk);
    end
  endtask

  // Monitor for the 8-bit receiver.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (u_if8.rx_done_o || u_if8.frame_err_o)) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe8: done=%0b ferr=%0b data=0x%0h, expected no strobe",
                 u_if8.rx_done_o, u_if8.frame_err_o, u_if8.rx_data_o);
      end else begin
        e = q8.pop_front();
        check("strobe_kind8", {30'd0, u_if8.rx_done_o, u_if8.frame_err_o},
              e.is_err ? 32'd1 : 32'd2);
        check("rx_data8", {24'd0, u_if8.rx_data_o}, {24'd0, e.data});
        if (!e.is_err) begin
          check("busy_fall8", {30'd0, prev_busy8, u_if8.busy_o}, 32'd2);
          done_cyc.push_back(cyc);
        end
      end
    end
    prev_busy8 = u_if8.busy_o;
  end

  // Monitor for the 7-bit, 8x-oversampled receiver.
  always @(negedge clk) begin
    logic [6:0] e7;
    if (!rst && (u_if7.rx_done_o || u_if7.frame_err_o)) begin
      if (q7.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe7: done=%0b ferr=%0b data=0x%0h, expected no strobe",
                 u_if7.rx_done_o, u_if7.frame_err_o, u_if7.rx_data_o);
      end else begin
        e7 = q7.pop_front();
        check("strobe_kind7", {30'd0, u_if7.rx_done_o, u_if7.frame_err_o}, 32'd2);
        check("rx_data7", {25'd0, u_if7.rx_data_o}, {25'd0, e7});
        check("busy_fall7", {30'd0, prev_busy7, u_if7.busy_o}, 32'd2);
      end
    end
    prev_busy7 = u_if7.busy_o;
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    prev_busy8 = 1'b0;
    prev_busy7 = 1'b0;
    rst        = 1'b1;
    u_if8.rx_i = 1'b1;
    u_if7.rx_i = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_busy", {31'd0, u_if8.busy_o}, 32'd0);
    check("reset_data", {24'd0, u_if8.rx_data_o}, 32'd0);
    check("reset_done", {31'd0, u_if8.rx_done_o}, 32'd0);
    check("reset_ferr", {31'd0, u_if8.frame_err_o}, 32'd0);
    check("reset_data7", {25'd0, u_if7.rx_data_o}, 32'd0);
    rst = 1'b0;
    repeat (200) @(negedge clk);

    // Good frame 0xA5.
    q8.push_back({1'b0, 8'hA5});
    send_raw({6'h3F, 1'b1, 8'hA5, 1'b0}, 10, BIT8, 0);
    repeat (300) @(negedge clk);
    check("good_drain", q8.size(), 32'd0);

    // Start glitch shorter than half a bit.
    u_if8.rx_i = 1'b0;
    repeat (300) @(negedge clk);
    u_if8.rx_i = 1'b1;
    repeat (400) @(negedge clk);
    check("glitch_busy", {31'd0, u_if8.busy_o}, 32'd0);
    check("glitch_data", {24'd0, u_if8.rx_data_o}, 32'h A5);

    // Framing error on 0x3C followed by a break.
    q8.push_back({1'b1, 8'hA5});
    send_raw({6'h00, 1'b0, 8'h3C, 1'b0}, 10, BIT8, 0);
    repeat (2500) @(negedge clk);
    check("break_busy", {31'd0, u_if8.busy_o}, 32'd1);
    repeat (2500) @(negedge clk);
    u_if8.rx_i = 1'b1;
    repeat (10) @(negedge clk);
    check("break_release_busy", {31'd0, u_if8.busy_o}, 32'd0);
    check("ferr_drain", q8.size(), 32'd0);
    check("ferr_data_kept", {24'd0, u_if8.rx_data_o}, 32'h A5);
    repeat (300) @(negedge clk);

    // Back-to-back 0x00 then 0xFF with no idle gap.
    done_cyc.delete();
    q8.push_back({1'b0, 8'h00});
    q8.push_back({1'b0, 8'hFF});
    send_raw({6'h3F, 1'b1, 8'h00, 1'b0}, 10, BIT8, 0);
    send_raw({6'h3F, 1'b1, 8'hFF, 1'b0}, 10, BIT8, 0);
    repeat (300) @(negedge clk);
    check("b2b_drain", q8.size(), 32'd0);
    check("b2b_count", done_cyc.size(), 32'd2);
    if (done_cyc.size() == 2) check("b2b_gap", done_cyc[1] - done_cyc[0], 32'd12480);

    // Reset during data bit 4 of 0x5A, then a full 0x5A frame.
    send_raw({11'h000, 4'hA, 1'b0}, 5, BIT8, 0);
    u_if8.rx_i = 1'b1;
    repeat (600) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, u_if8.busy_o}, 32'd0);
    check("rst_mid_data", {24'd0, u_if8.rx_data_o}, 32'd0);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("rst_mid_idle", {31'd0, u_if8.busy_o}, 32'd0);
    q8.push_back({1'b0, 8'h5A});
    send_raw({6'h3F, 1'b1, 8'h5A, 1'b0}, 10, BIT8, 0);
    repeat (300) @(negedge clk);
    check("rst_frame_drain", q8.size(), 32'd0);
    check("rst_frame_data", {24'd0, u_if8.rx_data_o}, 32'h5A);

    // Seven data bits at 8x oversampling.
    q7.push_back(7'h55);
    send_raw({7'h7F, 1'b1, 7'h55, 1'b0}, 9, BIT7, 1);
    repeat (300) @(negedge clk);
    check("p7_drain", q7.size(), 32'd0);
    check("p7_data", {25'd0, u_if7.rx_data_o}, 32'h55);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
